timer_dev: RTL and testbench

- Memory-mapped countdown timer on the bridge's TIMER0/TIMER1 windows. Two instances sit directly downstream of the address checker and bridge.
- The bridge forwards only accesses the address checker has already validated: word-sized, aligned, in-window, and no write to COUNT. The timer still handles any stray access safely.
- Provides three registers (CTRL, PRESET, COUNT) and a level interrupt request to the CP0/interrupt logic.

---
 rtl/timer_dev.sv | 126 ++++++++++++
 tb/tb_timer_dev.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot or
// auto-reload countdown, and a maskable level interrupt request.
module timer_dev #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    localparam logic [1:0]       MODE_RELOAD = 2'd1;
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    state_t           state, state_nx;
    logic             en, en_nx;
    logic [1:0]       mode, mode_nx;
    logic             im, im_nx;
    logic [WIDTH-1:0] preset, preset_nx;
    logic [WIDTH-1:0] count, count_nx;
    logic             irq_flag, irq_flag_nx;
    logic             ctrl_wr, preset_wr;

    assign ctrl_wr   = we && (addr == 2'd0);
    assign preset_wr = we && (addr == 2'd1);

    // NOTE: every next-value signal starts from its current value, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx    = state;
        en_nx       = en;
        mode_nx     = mode;
        im_nx       = im;
        preset_nx   = preset;
        count_nx    = count;
        irq_flag_nx = irq_flag;

        // Auto-reload turns the flag into a one-cycle pulse.
        if (irq_flag && mode == MODE_RELOAD) begin
            irq_flag_nx = 1'b0;
        end

        unique case (state)
            S_IDLE: begin
                if (en) state_nx = S_LOAD;
            end
            S_LOAD: begin
                count_nx = preset;
                state_nx = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_nx = S_IDLE;
                end else if (count > ONE) begin
                    count_nx = count - ONE;
                end else begin
                    count_nx = '0;
                    state_nx = S_INT;
                end
            end
            S_INT: begin
                irq_flag_nx = 1'b1;
                if (mode == MODE_RELOAD) begin
                    state_nx = S_LOAD;
                end else begin
                    en_nx    = 1'b0;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // CPU writes are applied last so they win over same-edge FSM updates.
        if (ctrl_wr) begin
            en_nx       = wdata[0];
            mode_nx     = wdata[2:1];
            im_nx       = wdata[3];
            irq_flag_nx = 1'b0;
        end
        if (preset_wr) begin
            preset_nx   = wdata[WIDTH-1:0];
            irq_flag_nx = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            en       <= 1'b0;
            mode     <= 2'd0;
            im       <= 1'b0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_nx;
            en       <= en_nx;
            mode     <= mode_nx;
            im       <= im_nx;
            preset   <= preset_nx;
            count    <= count_nx;
            irq_flag <= irq_flag_nx;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (addr)
            2'd0:    rdata = {28'd0, im, mode, en};
            2'd1:    rdata = 32'(preset);
            2'd2:    rdata = 32'(count);
            default: rdata = '0;
        endcase
    end

    assign irq = im & irq_flag;
endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: a behavioural model predicts each cycle's
// read data and irq; a negedge monitor compares them against the DUT.
module tb_timer_dev;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  addr  = 2'd0;
    logic        we    = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    timer_dev #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .addr (addr),
        .we   (we),
        .wdata(wdata),
        .rdata(rdata),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CNT = 2, PH_INT = 3;
    int          m_ph;
    bit          m_en, m_im, m_flag;
    bit [1:0]    m_mode;
    bit [31:0]   m_preset, m_count;

    function automatic void model_reset();
        m_ph = PH_IDLE; m_en = 0; m_im = 0; m_flag = 0;
        m_mode = 0; m_preset = 0; m_count = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_edge(input bit w, input logic [1:0] a, input logic [31:0] d);
        int        ph   = m_ph;
        bit        en   = m_en;
        bit        flag = m_flag;
        bit [31:0] cnt  = m_count;
        if (m_flag && m_mode == 2'd1) flag = 0;
        if (m_ph == PH_IDLE) begin
            if (m_en) ph = PH_LOAD;
        end else if (m_ph == PH_LOAD) begin
            cnt = m_preset;
            ph  = PH_CNT;
        end else if (m_ph == PH_CNT) begin
            if (!m_en) ph = PH_IDLE;
            else if (m_count > 1) cnt = m_count - 1;
            else begin cnt = 0; ph = PH_INT; end
        end else begin
            flag = 1;
            if (m_mode == 2'd1) ph = PH_LOAD;
            else begin en = 0; ph = PH_IDLE; end
        end
        m_ph = ph; m_en = en; m_flag = flag; m_count = cnt;
        if (w && a == 2'd0) begin
            m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_flag = 0;
        end
        if (w && a == 2'd1) begin
            m_preset = d; m_flag = 0;
        end
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]  a;
        logic [31:0] rd;
        logic        irq;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("sb rdata addr%0d", e.a), rdata, e.rd);
            check($sformatf("sb irq addr%0d", e.a), {31'd0, irq}, {31'd0, e.irq});
        end
    end

    // One bus cycle, entered at posedge+1: drive, predict, sample, advance.
    task automatic cycle(input bit w, input logic [1:0] a, input logic [31:0] d,
                         output logic [31:0] rd_obs, output logic irq_obs);
        exp_t e;
        we = w; addr = a; wdata = d;
        e.a = a; e.rd = model_read(a); e.irq = m_im & m_flag;
        exp_q.push_back(e);
        #3;
        rd_obs = rdata; irq_obs = irq;
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r; logic i;
        cycle(1'b1, a, d, r, i);
    endtask

    task automatic idle(input int n);
        logic [31:0] r; logic i;
        for (int k = 0; k < n; k++) cycle(1'b0, 2'(k % 3), 32'd0, r, i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd_v[40];
        logic        irq_v[40];
        logic [31:0] r;
        logic        i;
        int          first, pulses, guard;

        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 2'(k), 32'd0, r, i);
            check($sformatf("reset reg%0d", k), r, 32'd0);
        end
        check("reset irq", {31'd0, i}, 32'd0);

        // One-shot: PRESET=5, CTRL=0x9
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int k = 0; k < 10; k++) cycle(1'b0, 2'd2, 32'd0, rd_v[k], irq_v[k]);
        for (int k = 0; k < 6; k++) check($sformatf("oneshot count T%0d", k + 2), rd_v[k + 2], 32'(5 - k));
        check("oneshot irq T7", {31'd0, irq_v[7]}, 32'd0);
        check("oneshot irq T8", {31'd0, irq_v[8]}, 32'd1);
        cycle(1'b0, 2'd0, 32'd0, r, i);
        check("oneshot ctrl after", r, 32'h8);
        check("oneshot irq sticky", {31'd0, i}, 32'd1);
        wr(2'd0, 32'h0);
        cycle(1'b0, 2'd0, 32'd0, r, i);
        check("oneshot irq cleared", {31'd0, i}, 32'd0);

        // Auto-reload: PRESET=3, CTRL=0xB
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 0; k < 40; k++) cycle(1'b0, 2'd2, 32'd0, rd_v[k], irq_v[k]);
        first = -1;
        for (int k = 0; k < 40; k++) if (first < 0 && irq_v[k]) first = k;
        pulses = 0;
        if (first >= 0 && first + 18 < 40)
            for (int k = first + 1; k <= first + 18; k++) if (irq_v[k]) pulses++;
        check("reload pulses in 18 cycles", 32'(pulses), 32'd3);

        // Mask and preset 0
        wr(2'd0, 32'h0);
        idle(6);
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h1);
        for (int k = 0; k < 6; k++) cycle(1'b0, 2'd0, 32'd0, rd_v[k], irq_v[k]);
        check("mask ctrl T3 EN", rd_v[3], 32'h1);
        check("mask ctrl T4 EN cleared", rd_v[4], 32'h0);
        check("mask irq held low", {31'd0, irq_v[5]}, 32'd0);
        wr(2'd0, 32'h9);
        cycle(1'b0, 2'd0, 32'd0, r, i);
        check("mask irq after ctrl write", {31'd0, i}, 32'd0);

        // Read-only and reserved
        wr(2'd0, 32'h0);
        idle(6);
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h1);
        for (int k = 0; k < 4; k++) cycle(1'b0, 2'd2, 32'd0, rd_v[k], irq_v[k]);
        check("ro count T3", rd_v[3], 32'd19);
        cycle(1'b1, 2'd2, 32'hDEAD, r, i);
        check("ro count during write", r, 32'd18);
        cycle(1'b1, 2'd3, 32'hDEAD, r, i);
        check("ro addr3 reads 0", r, 32'd0);
        cycle(1'b0, 2'd2, 32'd0, r, i);
        check("ro count unaffected", r, 32'd16);
        cycle(1'b0, 2'd0, 32'd0, r, i);
        check("ro ctrl upper zero", r, 32'h1);

        // Disable mid-count
        wr(2'd0, 32'h0);
        idle(6);
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        guard = 0;
        while (!(m_ph == PH_CNT && m_count == 6) && guard < 40) begin
            idle(1); guard++;
        end
        check("dis reached count 6", {31'd0, guard < 40}, 32'd1);
        wr(2'd0, 32'h0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 2'd2, 32'd0, rd_v[k], irq_v[k]);
        check("dis count frozen", rd_v[3], 32'd5);
        check("dis no irq", {31'd0, irq_v[3]}, 32'd0);
        wr(2'd0, 32'h1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 2'd2, 32'd0, rd_v[k], irq_v[k]);
        check("dis reload 10", rd_v[2], 32'd10);

        // Async reset mid-operation, MODE 1 with COUNT=4
        wr(2'd0, 32'h0);
        idle(6);
        wr(2'd1, 32'd8);
        wr(2'd0, 32'hB);
        guard = 0;
        while (!(m_ph == PH_CNT && m_count == 4) && guard < 40) begin
            idle(1); guard++;
        end
        check("rst reached count 4", {31'd0, guard < 40}, 32'd1);
        #1 rst_n = 1'b0;
        #1 check("rst irq immediate", {31'd0, irq}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            addr = 2'(k);
            #1 check($sformatf("rst reg%0d immediate", k), rdata, 32'd0);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) cycle(1'b0, 2'd2, 32'd0, rd_v[k], irq_v[k]);
        check("rst stays idle count", rd_v[4], 32'd0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int sel = int'($urandom_range(0, 99));
            if (sel < 8)
                wr(2'd0, 32'($urandom_range(0, 15)) | ($urandom() & 32'hFFFF_FFF0));
            else if (sel < 14)
                wr(2'd1, (sel == 13) ? $urandom() : 32'($urandom_range(0, 9)));
            else if (sel < 17)
                wr(2'($urandom_range(2, 3)), $urandom());
            else
                cycle(1'b0, 2'($urandom_range(0, 3)), 32'd0, r, i);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
